// File: rtl/adc_stream_reporter_pkg.sv
// avr_stream_pkg: constants, TX FSM state type and small helpers shared by
// the ADC stream reporter and its channel averager.
//   FRAME_HDR  - upper nibble of byte0 of every frame
//   CMD_START  - 'S', starts streaming
//   CMD_PAUSE  - 'P', pauses streaming
//   FRAME_LEN  - bytes per frame
package avr_stream_pkg;

  localparam logic [3:0]  FRAME_HDR = 4'hA;
  localparam logic [7:0]  CMD_START = 8'h53;
  localparam logic [7:0]  CMD_PAUSE = 8'h50;
  localparam int unsigned FRAME_LEN = 3;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SEND,
    TX_GAP
  } tx_state_t;

  // Byte idx of the frame {FRAME_HDR,ch}, {6'b0,avg[9:8]}, avg[7:0].
  function automatic logic [7:0] frame_byte(input logic [3:0] ch,
                                            input logic [9:0] avg,
                                            input logic [1:0] idx);
    case (idx)
      2'd0:    frame_byte = {FRAME_HDR, ch};
      2'd1:    frame_byte = {6'b0, avg[9:8]};
      default: frame_byte = avg[7:0];
    endcase
  endfunction

  // Round-robin successor of ch within 0..num_ch-1.
  function automatic logic [3:0] next_channel(input logic [3:0] ch,
                                              input int unsigned num_ch);
    next_channel = (ch == 4'(num_ch - 1)) ? 4'd0 : ch + 4'd1;
  endfunction

endpackage

// File: rtl/adc_stream_reporter_if.sv
// adc_stream_reporter_if: ADC and serial user-interface signals between the
// AVR interface block (master) and the stream reporter (slave).
//   channel        ADC channel request          (slave -> master)
//   new_sample     one-cycle sample strobe      (master -> slave)
//   sample         10-bit ADC result            (master -> slave)
//   sample_channel channel of the sample        (master -> slave)
//   rx_data        received byte                (master -> slave)
//   new_rx_data    received-byte strobe         (master -> slave)
//   tx_data        byte to transmit             (slave -> master)
//   new_tx_data    one-cycle transmit request   (slave -> master)
//   tx_busy        serial transmitter busy      (master -> slave)
interface adc_stream_reporter_if;

  logic [3:0] channel;
  logic       new_sample;
  logic [9:0] sample;
  logic [3:0] sample_channel;
  logic [7:0] rx_data;
  logic       new_rx_data;
  logic [7:0] tx_data;
  logic       new_tx_data;
  logic       tx_busy;

  modport master (
    input  channel, tx_data, new_tx_data,
    output new_sample, sample, sample_channel, rx_data, new_rx_data, tx_busy
  );

  modport slave (
    output channel, tx_data, new_tx_data,
    input  new_sample, sample, sample_channel, rx_data, new_rx_data, tx_busy
  );

endinterface

// File: rtl/adc_stream_reporter_channel_averager.sv
// channel_averager: accumulates 2^AVG_SHIFT samples of the currently selected
// channel and then advances the channel round-robin over 0..NUM_CH-1.
//   clk, rst       clock, asynchronous active-high reset
//   clear          synchronous clear of all state
//   streaming      accumulate enable; while low the partial average is dropped
//   new_sample, sample, sample_channel   ADC sample stream
//   channel        registered channel request
//   done           completion strobe, same cycle as the final matching sample
//   avg            average of the completed set (valid with done)
module channel_averager
  import avr_stream_pkg::*;
#(
  parameter int unsigned NUM_CH    = 8,
  parameter int unsigned AVG_SHIFT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       streaming,
  input  logic       new_sample,
  input  logic [9:0] sample,
  input  logic [3:0] sample_channel,
  output logic [3:0] channel,
  output logic       done,
  output logic [9:0] avg
);

  localparam int unsigned ACC_W    = 10 + AVG_SHIFT;
  localparam logic [4:0]  CNT_LAST = 5'((1 << AVG_SHIFT) - 1);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [4:0]       cnt;
  logic             hit;
  logic             last;

  always_comb begin
    hit     = streaming && new_sample && (sample_channel == channel);
    last    = (cnt == CNT_LAST);
    acc_sum = acc + ACC_W'(sample);
    done    = hit && last;
    avg     = acc_sum[AVG_SHIFT+9:AVG_SHIFT];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      cnt     <= '0;
      channel <= '0;
    end else if (clear) begin
      acc     <= '0;
      cnt     <= '0;
      channel <= '0;
    end else if (!streaming) begin
      // Pausing discards the partial average but keeps the channel.
      acc <= '0;
      cnt <= '0;
    end else if (hit) begin
      if (last) begin
        acc     <= '0;
        cnt     <= '0;
        channel <= next_channel(channel, NUM_CH);
      end else begin
        acc <= acc_sum;
        cnt <= cnt + 5'd1;
      end
    end
  end

endmodule

// File: rtl/adc_stream_reporter.sv
// adc_stream_reporter: scans ADC channels, averages each one and sends every
// average as a 3-byte frame over the serial TX user interface. Streaming is
// started/paused by 'S'/'P' bytes on the serial RX user interface.
//   clk, rst    clock, asynchronous active-high reset
//   ready       AVR ready; low clears all state synchronously
//   bus         ADC/serial signals (slave modport)
//   streaming   run flag
//   overrun     one-cycle pulse when a completed average is dropped
module adc_stream_reporter
  import avr_stream_pkg::*;
#(
  parameter int unsigned NUM_CH    = 8,
  parameter int unsigned AVG_SHIFT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ready,
  adc_stream_reporter_if.slave  bus,
  output logic                  streaming,
  output logic                  overrun
);

  logic       clear;
  logic [3:0] channel_q;
  logic       done;
  logic [9:0] done_avg;

  logic       slot_valid;
  logic [3:0] slot_ch;
  logic [9:0] slot_avg;
  logic       slot_take;

  tx_state_t  state;
  logic [3:0] fr_ch;
  logic [9:0] fr_avg;
  logic [1:0] idx;
  logic [7:0] tx_data_q;
  logic       new_tx_q;

  always_comb begin
    clear     = !ready;
    slot_take = (state == TX_IDLE) && slot_valid;
  end

  channel_averager #(
    .NUM_CH    (NUM_CH),
    .AVG_SHIFT (AVG_SHIFT)
  ) u_averager (
    .clk            (clk),
    .rst            (rst),
    .clear          (clear),
    .streaming      (streaming),
    .new_sample     (bus.new_sample),
    .sample         (bus.sample),
    .sample_channel (bus.sample_channel),
    .channel        (channel_q),
    .done           (done),
    .avg            (done_avg)
  );

  assign bus.channel     = channel_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.new_tx_data = new_tx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streaming  <= 1'b0;
      overrun    <= 1'b0;
      slot_valid <= 1'b0;
      slot_ch    <= '0;
      slot_avg   <= '0;
      state      <= TX_IDLE;
      fr_ch      <= '0;
      fr_avg     <= '0;
      idx        <= '0;
      tx_data_q  <= '0;
      new_tx_q   <= 1'b0;
    end else if (clear) begin
      streaming  <= 1'b0;
      overrun    <= 1'b0;
      slot_valid <= 1'b0;
      slot_ch    <= '0;
      slot_avg   <= '0;
      state      <= TX_IDLE;
      fr_ch      <= '0;
      fr_avg     <= '0;
      idx        <= '0;
      tx_data_q  <= '0;
      new_tx_q   <= 1'b0;
    end else begin
      overrun  <= 1'b0;
      new_tx_q <= 1'b0;

      if (bus.new_rx_data) begin
        if (bus.rx_data == CMD_START) begin
          streaming <= 1'b1;
        end else if (bus.rx_data == CMD_PAUSE) begin
          streaming <= 1'b0;
        end
      end

      // A slot freed by the FSM this cycle can take a simultaneous result.
      if (slot_take) begin
        slot_valid <= 1'b0;
      end
      if (done) begin
        if (!slot_valid || slot_take) begin
          slot_valid <= 1'b1;
          slot_ch    <= channel_q;
          slot_avg   <= done_avg;
        end else begin
          overrun <= 1'b1;
        end
      end

      case (state)
        TX_IDLE: begin
          if (slot_valid) begin
            fr_ch  <= slot_ch;
            fr_avg <= slot_avg;
            idx    <= 2'd0;
            // Loading and the first SEND decision share this cycle so the
            // byte0 strobe lands two cycles after the final sample.
            if (!bus.tx_busy) begin
              tx_data_q <= frame_byte(slot_ch, slot_avg, 2'd0);
              new_tx_q  <= 1'b1;
              state     <= TX_GAP;
            end else begin
              state <= TX_SEND;
            end
          end
        end
        TX_SEND: begin
          if (!bus.tx_busy) begin
            tx_data_q <= frame_byte(fr_ch, fr_avg, idx);
            new_tx_q  <= 1'b1;
            state     <= TX_GAP;
          end
        end
        TX_GAP: begin
          if (idx == 2'(FRAME_LEN - 1)) begin
            state <= TX_IDLE;
          end else begin
            idx   <= idx + 2'd1;
            state <= TX_SEND;
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: doc/adc_stream_reporter.md
# adc_stream_reporter

Downstream consumer of the AVR interface block's ADC and serial ports. It drives the ADC channel select and round-robins channels 0..NUM_CH-1. Each channel is averaged over 2^AVG_SHIFT samples, and every average is sent as a 3-byte frame on the serial TX user interface. Streaming is started and paused by single-byte commands arriving on the serial RX user interface.

## Interface
- NUM_CH, 8: channels scanned, 1..16; scan order 0..NUM_CH-1.
- AVG_SHIFT, 2: log2 of samples per average, 0..4.
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- ready  in  1  AVR ready; low acts as synchronous clear of all state
- channel  out  4  ADC channel request (to `channel` of interface block)
- new_sample  in  1  one-cycle sample strobe
- sample  in  10  ADC result
- sample_channel  in  4  channel the sample belongs to
- rx_data  in  8  received byte
- new_rx_data  in  1  one-cycle received-byte strobe
- tx_data  out  8  byte to transmit
- new_tx_data  out  1  one-cycle transmit request
- tx_busy  in  1  serial transmitter busy
- streaming  out  1  run flag
- overrun  out  1  one-cycle pulse when a completed average is dropped

## Operation
- Reset/ready=0 state: channel=0, tx_data=0, new_tx_data=0, streaming=0, overrun=0, accumulator/count cleared, pending slot empty, TX FSM IDLE.
- Commands: new_rx_data with rx_data=0x53 ('S') sets streaming. 0x50 ('P') clears it. Other bytes are ignored.
- Clearing streaming clears the accumulator and count. It does not cancel the pending slot or a frame in flight. The channel is held.
- Accumulate only when streaming && new_sample && sample_channel==channel. Mismatched samples are ignored.
- Accumulator width is 10+AVG_SHIFT bits and cannot overflow. avg = acc[AVG_SHIFT+9:AVG_SHIFT] (truncating).
- On the 2^AVG_SHIFT-th matching sample:
  - {channel, avg} is written to the pending slot.
  - The accumulator is cleared.
  - channel advances, wrapping NUM_CH-1 to 0.
- If the pending slot is full at completion, the new result is dropped, overrun pulses, and the channel still advances.
- Frame layout: byte0={4'hA, ch}, byte1={6'b0, avg[9:8]}, byte2=avg[7:0].
- TX FSM states:
  - IDLE: if the pending slot is valid, load the frame, free the slot, go to SEND with idx=0.
  - SEND: if !tx_busy, drive tx_data=byte[idx] with new_tx_data=1 for one cycle, then go to GAP.
  - GAP: one cycle, tx_busy is ignored. If idx==2 go to IDLE, else idx++ and go to SEND.
- Simultaneous events:
  - Slot freed by IDLE in the same cycle as a completion: the new result is accepted, no overrun.
  - Command arrives in the same cycle as a final sample: the sample is processed first, the command takes effect for later samples.

## Timing
- Final matching new_sample in cycle N: the pending slot is valid in N+1, and new_tx_data for byte0 is high in N+2 (TX idle, tx_busy low).
- With tx_busy low throughout, the three byte strobes occur 2 cycles apart. Frame latency otherwise depends on tx_busy.
- All outputs are registered. new_tx_data is never high on consecutive cycles.
- rst asserted mid-frame: outputs take their reset values immediately. ready low: same values on the next edge. No partial frame resumes.

## Structure
- Package avr_stream_pkg holds:
  - FRAME_HDR=4'hA
  - CMD_START=8'h53, CMD_PAUSE=8'h50
  - FRAME_LEN=3
  - the TX FSM state enum
- Sub-module channel_averager holds the accumulator, sample count, channel counter and completion strobe. The top level contains the command decode, pending slot and TX FSM.

## Test plan
- NUM_CH=2, AVG_SHIFT=2. Send 'S', then ch0 samples 100,101,102,103 → frame 0xA0,0x00,0x65 and channel becomes 1.
- Interleave sample_channel=5 samples with value 1023 among the ch0 samples → average unchanged, exactly 4 matching samples counted.
- Hold tx_busy high 20 cycles after byte0 → no new_tx_data until tx_busy falls, then byte1 appears 1 cycle later.
- tx_busy held high while 3 averages complete → first frame in FSM, second pending, third dropped with one overrun pulse. After tx_busy releases, frames for ch0 and ch1 are sent and the channel wraps to 0.
- 'P' after 2 of 4 samples, then 'S' → the next average uses 4 fresh samples only. No samples are accumulated while paused.
- ready low during byte1 → new_tx_data=0, streaming=0, channel=0 next cycle. After ready returns, nothing is transmitted until 'S'.
